// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

  // Stores only come in B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = offset[0];
      F3_W:        mis = (offset != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// byte/half store data into an existing memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] byte_shift_s;
  logic [31:0] half_shift_s;
  logic [31:0] lane_mask_s;
  logic [31:0] lane_data_s;

  assign byte_shift_s = word >> {offset, 3'b000};
  assign half_shift_s = word >> {offset[1], 4'b0000};

  // Load extraction with sign or zero extension
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{byte_shift_s[7]}}, byte_shift_s[7:0]};
      F3_H:    load_data = {{16{half_shift_s[15]}}, half_shift_s[15:0]};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h00_0000, byte_shift_s[7:0]};
      F3_HU:   load_data = {16'h0000, half_shift_s[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store lane selection: replicate the data, then keep only the target lane
  always_comb begin
    lane_mask_s = 32'h0000_0000;
    lane_data_s = 32'h0000_0000;
    case (funct3)
      F3_B: begin
        lane_mask_s = 32'h0000_00FF << {offset, 3'b000};
        lane_data_s = {4{wdata[7:0]}};
      end
      F3_H: begin
        lane_mask_s = 32'h0000_FFFF << {offset[1], 4'b0000};
        lane_data_s = {2{wdata[15:0]}};
      end
      F3_W: begin
        lane_mask_s = 32'hFFFF_FFFF;
        lane_data_s = wdata;
      end
      default: begin
        lane_mask_s = 32'h0000_0000;
        lane_data_s = 32'h0000_0000;
      end
    endcase
  end

  assign merge_data = (word & ~lane_mask_s) | (lane_data_s & lane_mask_s);

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit: one request at a time, word-wide memory,
// read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  lsu_state_t  state_r, state_next_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r, merge_r, rdata_r;
  logic        misalign_r, fault_r;

  logic        accept_s, req_fault_s, req_misalign_s;
  logic [31:0] align_word_s, load_data_s, merge_data_s;

  assign accept_s       = req_valid & (state_r == IDLE);
  assign req_fault_s    = ~f3_legal(req_we, req_funct3) | (req_addr >= ADDR_LIMIT);
  assign req_misalign_s = f3_legal(req_we, req_funct3) & is_misaligned(req_funct3, req_addr[1:0]);

  // Lane logic sees live memory data in ACCESS and the captured word in MERGE_WR
  always_comb begin
    if (state_r == MERGE_WR) begin
      align_word_s = merge_r;
    end else begin
      align_word_s = mem_rd;
    end
  end

  lsu_align u_align (
    .word       (align_word_s),
    .offset     (addr_r[1:0]),
    .funct3     (funct3_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; rejected requests skip memory entirely
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_fault_s | req_misalign_s) begin
            state_next_s = RESP;
          end else begin
            state_next_s = ACCESS;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r && (funct3_r != F3_W)) begin
          state_next_s = MERGE_WR;
        end else begin
          state_next_s = RESP;
        end
      end
      MERGE_WR: state_next_s = RESP;
      RESP:     state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // Request capture and response data; results hold until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r       <= 1'b0;
      funct3_r   <= 3'b000;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      merge_r    <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      misalign_r <= 1'b0;
      fault_r    <= 1'b0;
    end else if (accept_s) begin
      we_r       <= req_we;
      funct3_r   <= req_funct3;
      addr_r     <= req_addr;
      wdata_r    <= req_wdata;
      rdata_r    <= 32'h0000_0000;
      misalign_r <= req_misalign_s;
      fault_r    <= req_fault_s;
    end else if (state_r == ACCESS) begin
      if (we_r) begin
        merge_r <= mem_rd;
      end else begin
        rdata_r <= load_data_s;
      end
    end
  end

  // Memory strobes come from state alone so a reset kills a pending write at once
  always_comb begin
    mem_we = 1'b0;
    mem_wd = 32'h0000_0000;
    if ((state_r == ACCESS) && we_r && (funct3_r == F3_W)) begin
      mem_we = 1'b1;
      mem_wd = wdata_r;
    end else if (state_r == MERGE_WR) begin
      mem_we = 1'b1;
      mem_wd = merge_data_s;
    end else begin
      mem_we = 1'b0;
      mem_wd = 32'h0000_0000;
    end
  end

  assign mem_a        = {addr_r[31:2], 2'b00};
  assign req_ready    = (state_r == IDLE);
  assign rsp_valid    = (state_r == RESP);
  assign rsp_rdata    = rdata_r;
  assign rsp_misalign = misalign_r;
  assign rsp_fault    = fault_r;

endmodule
